// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 max-pool row controller.
// Holds the FSM state encoding and the signed max helper.
package pool_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    EVEN,
    ODD,
    WRITE,
    READ
  } pool_state_e;

  function automatic logic [DATA_W-1:0] smax(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return ($signed(a) < $signed(b)) ? b : a;
  endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational signed two-input maximum.
// Used for both the horizontal and the vertical pooling stage.
module pool_max2
  import pool_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  if (W == DATA_W) begin : g_pkg
    assign y_o = smax(a_i, b_i);
  end else begin : g_gen
    assign y_o = ($signed(a_i) < $signed(b_i)) ? b_i : a_i;
  end

endmodule

// File: rtl/max_pool_row_ctrl.sv
// Row-pair 2x2/stride-2 max-pool front end feeding the PIPO_pool bank.
// Pools two accepted rows, then issues a write and a read strobe.
module max_pool_row_ctrl
  import pool_pkg::*;
#(
  parameter int data_width = DATA_W,
  parameter int in_num     = 40,
  parameter int out_num    = 20,
  parameter int row_num    = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_row [in_num],
  output logic [data_width-1:0] out_row [out_num],
  output logic                  pool_wr,
  output logic                  pool_rd,
  output logic                  frame_done
);

  localparam int CW = $clog2(row_num + 1);

  if (in_num != 2 * out_num || in_num % 2 != 0 ||
      row_num % 2 != 0 || row_num < 2) begin : g_bad_geom
    $error("max_pool_row_ctrl: illegal in_num/out_num/row_num");
  end

  pool_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [data_width-1:0] buf_q [out_num];
  logic [data_width-1:0] buf_d [out_num];
  logic [data_width-1:0] out_q [out_num];
  logic [data_width-1:0] out_d [out_num];
  logic [data_width-1:0] h [out_num];
  logic [data_width-1:0] v [out_num];
  logic                  wr_q, rd_q, fd_q;
  logic                  accept;

  for (genvar j = 0; j < out_num; j++) begin : g_pool
    pool_max2 #(.W(data_width)) u_h (
      .a_i(in_row[2*j]),
      .b_i(in_row[2*j+1]),
      .y_o(h[j])
    );
    pool_max2 #(.W(data_width)) u_v (
      .a_i(buf_q[j]),
      .b_i(h[j]),
      .y_o(v[j])
    );
  end

  assign in_ready = ~rst & ((state_q == EVEN) | (state_q == ODD));
  assign accept   = in_valid & in_ready;

  // Next-state, row buffer, pooled row and pair counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    out_d   = out_q;
    unique case (state_q)
      EVEN: begin
        if (accept) begin
          buf_d   = h;
          state_d = ODD;
        end
      end
      ODD: begin
        if (accept) begin
          out_d   = v;
          cnt_d   = (cnt_q == CW'(row_num - 2)) ? '0 : cnt_q + CW'(2);
          state_d = WRITE;
        end
      end
      WRITE:   state_d = READ;
      READ:    state_d = EVEN;
      default: state_d = EVEN;
    endcase
  end

  // State and datapath registers; strobes registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EVEN;
      cnt_q   <= '0;
      buf_q   <= '{default: '0};
      out_q   <= '{default: '0};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      wr_q    <= (state_d == WRITE);
      rd_q    <= (state_d == READ);
      fd_q    <= (state_d == READ) && (cnt_q == '0);
    end
  end

  assign out_row    = out_q;
  assign pool_wr    = wr_q;
  assign pool_rd    = rd_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_max_pool_row_ctrl.sv
// Self-checking bench for max_pool_row_ctrl.
// Table vectors, directed corners and a random stream vs a row-pair model.
module tb_max_pool_row_ctrl;

  localparam int DW = 16;
  localparam int IN = 40;
  localparam int ON = 20;
  localparam int RN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_row [IN];
  logic [DW-1:0] out_row [ON];
  logic          pool_wr, pool_rd, frame_done;

  always #5 clk = ~clk;

  max_pool_row_ctrl #(
    .data_width(DW),
    .in_num(IN),
    .out_num(ON),
    .row_num(RN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_row(in_row),
    .out_row(out_row),
    .pool_wr(pool_wr),
    .pool_rd(pool_rd),
    .frame_done(frame_done)
  );

  int total = 0;
  int bad = 0;

  int busy = 0;
  int racc = 0;
  int pairs = 0;
  bit fend = 0;
  bit known = 0;
  bit took = 0;
  int first [IN];
  int cur [IN];
  int expo [ON];

  typedef struct {
    bit v;
    bit rdy;
    bit wr;
    bit rd;
    bit fd;
  } vec_t;

  vec_t tbl [12];

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", n, act, exp);
    end
  endtask

  task automatic rand_row();
    logic [DW-1:0] t;
    for (int j = 0; j < IN; j++) begin
      t = DW'($urandom);
      cur[j] = int'($signed(t));
    end
  endtask

  task automatic drive(input bit v, input bit r);
    in_valid = v;
    rst = r;
    for (int j = 0; j < IN; j++) in_row[j] = DW'(cur[j]);
    #1;
    chk("in_ready", int'(in_ready), int'(!r && busy == 0));
    if (known) begin
      chk("pool_wr", int'(pool_wr), int'(busy == 2));
      chk("pool_rd", int'(pool_rd), int'(busy == 1));
      chk("frame_done", int'(frame_done), int'(busy == 1 && fend));
      chk("wr_rd_excl", int'(pool_wr && pool_rd), 0);
      for (int j = 0; j < ON; j++)
        chk($sformatf("out_row[%0d]", j),
            int'($signed(out_row[j])), expo[j]);
    end
  endtask

  task automatic advance();
    took = 0;
    if (rst) begin
      busy  = 0;
      racc  = 0;
      pairs = 0;
      fend  = 0;
      for (int j = 0; j < ON; j++) expo[j] = 0;
    end else if (busy > 0) begin
      busy--;
    end else if (in_valid) begin
      took = 1;
      if (racc % 2 == 0) begin
        first = cur;
      end else begin
        for (int j = 0; j < ON; j++)
          expo[j] = max4(first[2*j], first[2*j+1],
                         cur[2*j], cur[2*j+1]);
        busy  = 2;
        pairs++;
        fend  = (pairs % (RN / 2) == 0);
      end
      racc++;
    end
    @(posedge clk);
    if (rst) known = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 1); advance();
    drive(0, 1); advance();
  endtask

  initial begin
    for (int j = 0; j < IN; j++) cur[j] = 0;
    for (int j = 0; j < ON; j++) expo[j] = 0;
    for (int k = 0; k < 12; k++) begin
      tbl[k].v   = 1'b1;
      tbl[k].rdy = (k % 4) < 2;
      tbl[k].wr  = (k % 4) == 2;
      tbl[k].rd  = (k % 4) == 3;
      tbl[k].fd  = (k == 7);
    end

    do_reset();

    // single pair: ascending row then constant 5
    for (int j = 0; j < IN; j++) cur[j] = j;
    drive(1, 0); advance();
    for (int j = 0; j < IN; j++) cur[j] = 5;
    drive(1, 0); advance();
    drive(0, 0);
    chk("pair_wr", int'(pool_wr), 1);
    chk("pair_out0", int'(out_row[0]), 5);
    chk("pair_out10", int'(out_row[10]), 21);
    chk("pair_out19", int'(out_row[19]), 39);
    advance();
    drive(0, 0);
    chk("pair_rd", int'(pool_rd), 1);
    advance();

    // signed compare
    for (int j = 0; j < IN; j++) cur[j] = (j % 2 == 0) ? -3 : -7;
    drive(1, 0); advance();
    for (int j = 0; j < IN; j++) cur[j] = (j % 2 == 0) ? -10 : -1;
    drive(1, 0); advance();
    drive(0, 0);
    chk("signed_out0", int'(out_row[0]), 32'h0000_FFFF);
    advance();
    drive(0, 0); advance();

    // continuous valid: backpressure and frame end
    do_reset();
    rand_row();
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].v, 0);
      chk($sformatf("tbl%0d_rdy", k), int'(in_ready), int'(tbl[k].rdy));
      chk($sformatf("tbl%0d_wr", k), int'(pool_wr), int'(tbl[k].wr));
      chk($sformatf("tbl%0d_rd", k), int'(pool_rd), int'(tbl[k].rd));
      chk($sformatf("tbl%0d_fd", k), int'(frame_done), int'(tbl[k].fd));
      advance();
      if (took) rand_row();
    end

    // mid-pair reset discards the buffered row
    drive(1, 0); advance();
    rand_row();
    drive(1, 1); advance();
    drive(1, 1);
    chk("rst_wr", int'(pool_wr), 0);
    chk("rst_out3", int'(out_row[3]), 0);
    advance();
    drive(0, 0);
    chk("rdy_after_rst", int'(in_ready), 1);
    advance();

    // random gaps
    for (int c = 0; c < 400; c++) begin
      drive(bit'($urandom_range(0, 2) != 0), 0);
      advance();
      if (took) rand_row();
    end
    drive(0, 0); advance();
    drive(0, 0); advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
